aer_spike_encoder: RTL and testbench

- Transmit end of the neuron spike interface: collects the per-neuron spike_out pulses of an array of leaky_integrate_fire neurons.
- At each timestep boundary, serialises the spikes of the closed timestep as address-events (AER) on a valid/ready stream, lowest index first.
- Closes each timestep with an end-of-timestep (EOT) marker.
- Feeds the downstream router/decoder that rebuilds spike_in vectors for the next layer.

---
 rtl/snn_pkg.sv | 24 ++
 rtl/aer_spike_encoder_if.sv | 34 +++
 rtl/aer_spike_encoder_prio_enc_lsb.sv | 27 ++
 rtl/aer_spike_encoder.sv | 148 ++++++++++++++
 tb/tb_aer_spike_encoder.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network AER blocks.
// Contents:
//   aer_state_e   - encoder FSM states (IDLE, SEND, EOT)
//   aer_event_t   - address-event record (addr, eot) at the default width
//   AER_EOT_ADDR  - address value carried by an end-of-timestep event
//   DEF_N_NEURONS / DEF_ADDR_W - default array size and matching address width
package snn_pkg;

    localparam int DEF_N_NEURONS = 8;
    localparam int DEF_ADDR_W    = 3;
    localparam int AER_EOT_ADDR  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        EOT  = 2'd2
    } aer_state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic                  eot;
    } aer_event_t;

endpackage

// File: rtl/aer_spike_encoder_if.sv
// Address-event stream between the spike encoder and the downstream router.
// Signals:
//   aer_valid - event present (master)
//   aer_ready - sink accepts the event (slave)
//   aer_addr  - neuron index, AER_EOT_ADDR during an EOT event (master)
//   aer_eot   - end-of-timestep marker, qualified by aer_valid (master)
// Handshake: an event transfers on a cycle where aer_valid & aer_ready. Once
// aer_valid is high, aer_valid/aer_addr/aer_eot hold stable until that
// transfer; aer_valid only falls after a transfer (or on reset). aer_ready
// carries no meaning while aer_valid is low.
interface aer_spike_encoder_if #(
    parameter int ADDR_W = 3
) ();

    logic              aer_valid;
    logic              aer_ready;
    logic [ADDR_W-1:0] aer_addr;
    logic              aer_eot;

    modport master (
        output aer_valid,
        output aer_addr,
        output aer_eot,
        input  aer_ready
    );

    modport slave (
        input  aer_valid,
        input  aer_addr,
        input  aer_eot,
        output aer_ready
    );

endinterface

// File: rtl/aer_spike_encoder_prio_enc_lsb.sv
// Lowest-set-bit index encoder, purely combinational.
// Ports:
//   i_vec - N-bit request vector
//   o_idx - index of the lowest set bit (0 when i_vec is empty)
//   o_nz  - high when any bit of i_vec is set
module prio_enc_lsb #(
    parameter int N      = 8,
    parameter int ADDR_W = 3
) (
    input  logic [N-1:0]      i_vec,
    output logic [ADDR_W-1:0] o_idx,
    output logic              o_nz
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = ADDR_W'(i);
            end
        end
    end

    assign o_nz = |i_vec;

endmodule

// File: rtl/aer_spike_encoder.sv
// Transmit side of the neuron spike interface. Spikes accumulate in a
// collecting window (pending); a tick closes the window into the draining
// window (active), which is sent lowest index first as address-events and
// terminated with an EOT event.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   spike_in      - one-cycle spike pulses, bit i = neuron i
//   tick          - one-cycle pulse closing the current timestep
//   aer           - AER stream (master side)
//   busy          - high while not IDLE
//   drop_cnt      - saturating count of spikes that hit an already-set bit
//   tick_overrun  - sticky, a tick arrived while busy
//   dbg_state     - current FSM state
module aer_spike_encoder
    import snn_pkg::*;
#(
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_NEURONS-1:0] spike_in,
    input  logic                 tick,
    aer_spike_encoder_if.master  aer,
    output logic                 busy,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 tick_overrun,
    output aer_state_e           dbg_state
);

    localparam int SUM_W = CNT_W + ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    aer_state_e           r_state;
    logic [N_NEURONS-1:0] r_pending;
    // Bits of the draining window not yet presented; the bit on aer_addr is
    // already removed, so the next index is ready when the handshake lands.
    logic [N_NEURONS-1:0] r_active;

    logic [N_NEURONS-1:0] w_window;
    logic [N_NEURONS-1:0] w_enc_in;
    logic [N_NEURONS-1:0] w_enc_clr;
    logic [N_NEURONS-1:0] w_hits;
    logic [ADDR_W-1:0]    w_idx;
    logic                 w_nz;
    logic                 w_handshake;
    logic [SUM_W-1:0]     w_drop_num;
    logic [SUM_W-1:0]     w_drop_sum;
    logic [CNT_W-1:0]     w_drop_next;

    assign w_window    = r_pending | spike_in;
    // One encoder serves both the tick (closing window) and the drain.
    assign w_enc_in    = (r_state == IDLE) ? w_window : r_active;
    assign w_enc_clr   = w_enc_in & ~({{(N_NEURONS-1){1'b0}}, 1'b1} << w_idx);
    assign w_hits      = r_pending & spike_in;
    assign w_handshake = aer.aer_valid & aer.aer_ready;
    assign dbg_state   = r_state;

    prio_enc_lsb #(
        .N      (N_NEURONS),
        .ADDR_W (ADDR_W)
    ) u_prio_enc (
        .i_vec (w_enc_in),
        .o_idx (w_idx),
        .o_nz  (w_nz)
    );

    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            w_drop_num = w_drop_num + SUM_W'(w_hits[i]);
        end
        w_drop_sum = SUM_W'(drop_cnt) + w_drop_num;
        if (w_drop_sum > SUM_W'(CNT_MAX)) begin
            w_drop_next = CNT_MAX;
        end else begin
            w_drop_next = w_drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_pending     <= '0;
            r_active      <= '0;
            aer.aer_valid <= 1'b0;
            aer.aer_addr  <= '0;
            aer.aer_eot   <= 1'b0;
            busy          <= 1'b0;
            drop_cnt      <= '0;
            tick_overrun  <= 1'b0;
        end else begin
            drop_cnt  <= w_drop_next;
            r_pending <= w_window;
            if (tick && (r_state != IDLE)) begin
                tick_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (tick) begin
                        r_pending     <= '0;
                        aer.aer_valid <= 1'b1;
                        busy          <= 1'b1;
                        if (w_nz) begin
                            r_active     <= w_enc_clr;
                            aer.aer_addr <= w_idx;
                            aer.aer_eot  <= 1'b0;
                            r_state      <= SEND;
                        end else begin
                            r_active     <= '0;
                            aer.aer_addr <= ADDR_W'(AER_EOT_ADDR);
                            aer.aer_eot  <= 1'b1;
                            r_state      <= EOT;
                        end
                    end
                end
                SEND: begin
                    if (w_handshake) begin
                        if (w_nz) begin
                            r_active     <= w_enc_clr;
                            aer.aer_addr <= w_idx;
                        end else begin
                            aer.aer_addr <= ADDR_W'(AER_EOT_ADDR);
                            aer.aer_eot  <= 1'b1;
                            r_state      <= EOT;
                        end
                    end
                end
                EOT: begin
                    if (w_handshake) begin
                        aer.aer_valid <= 1'b0;
                        aer.aer_eot   <= 1'b0;
                        busy          <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    aer.aer_valid <= 1'b0;
                    aer.aer_eot   <= 1'b0;
                    busy          <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Testbench for aer_spike_encoder: table of per-cycle vectors followed by
// hand-written sequences for drop-counter saturation and reset mid-drain.
module tb_aer_spike_encoder;
    import snn_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 1: default widths ----------------
    logic [7:0] spike_in = '0;
    logic       tick = 1'b0;
    logic       busy;
    logic [7:0] drop_cnt;
    logic       tick_overrun;
    aer_state_e dbg_state;
    aer_spike_encoder_if #(.ADDR_W(3)) aer1 ();

    aer_spike_encoder #(.N_NEURONS(8), .ADDR_W(3), .CNT_W(8)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .spike_in     (spike_in),
        .tick         (tick),
        .aer          (aer1.master),
        .busy         (busy),
        .drop_cnt     (drop_cnt),
        .tick_overrun (tick_overrun),
        .dbg_state    (dbg_state)
    );

    // ---------------- DUT 2: 2-bit drop counter ----------------
    logic [7:0] spike_in2 = '0;
    logic       tick2 = 1'b0;
    logic       busy2;
    logic [1:0] drop_cnt2;
    logic       tick_overrun2;
    aer_state_e dbg_state2;
    aer_spike_encoder_if #(.ADDR_W(3)) aer2 ();

    aer_spike_encoder #(.N_NEURONS(8), .ADDR_W(3), .CNT_W(2)) u_dut2 (
        .clk          (clk),
        .reset_n      (reset_n),
        .spike_in     (spike_in2),
        .tick         (tick2),
        .aer          (aer2.master),
        .busy         (busy2),
        .drop_cnt     (drop_cnt2),
        .tick_overrun (tick_overrun2),
        .dbg_state    (dbg_state2)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic v, input logic [2:0] a,
                               input logic e, input logic b, input logic [7:0] d,
                               input logic o);
        chk({tag, ".valid"}, 32'(aer1.aer_valid), 32'(v));
        chk({tag, ".addr"},  32'(aer1.aer_addr),  32'(a));
        chk({tag, ".eot"},   32'(aer1.aer_eot),   32'(e));
        chk({tag, ".busy"},  32'(busy),           32'(b));
        chk({tag, ".drop"},  32'(drop_cnt),       32'(d));
        chk({tag, ".ovr"},   32'(tick_overrun),   32'(o));
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] spike;
        logic       tick;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_addr;
        logic       exp_eot;
        logic       exp_busy;
        logic [7:0] exp_drop;
        logic       exp_ovr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [7:0] s, input logic t, input logic r,
                       input logic v, input logic [2:0] a, input logic e,
                       input logic b, input logic [7:0] d, input logic o);
        vec_t x;
        x.spike = s; x.tick = t; x.ready = r;
        x.exp_valid = v; x.exp_addr = a; x.exp_eot = e;
        x.exp_busy = b; x.exp_drop = d; x.exp_ovr = o;
        vq.push_back(x);
    endtask

    initial begin
        aer1.aer_ready = 1'b1;
        aer2.aer_ready = 1'b1;

        // Inputs of each row are applied for one cycle; expectations are the
        // outputs just after that clock edge.
        //   spike  tk rd   valid addr eot busy drop ovr
        // basic: bits 2 and 5
        add(8'h24, 0, 1,  0, 0, 0, 0, 0, 0);
        add(8'h00, 1, 1,  1, 2, 0, 1, 0, 0);
        add(8'h00, 0, 1,  1, 5, 0, 1, 0, 0);
        add(8'h00, 0, 1,  1, 0, 1, 1, 0, 0);
        add(8'h00, 0, 1,  0, 0, 0, 0, 0, 0);
        // empty window
        add(8'h00, 1, 1,  1, 0, 1, 1, 0, 0);
        add(8'h00, 0, 1,  0, 0, 0, 0, 0, 0);
        // backpressure: bits 0 and 7, ready low for 4 cycles, then on EOT
        add(8'h81, 0, 1,  0, 0, 0, 0, 0, 0);
        add(8'h00, 1, 0,  1, 0, 0, 1, 0, 0);
        add(8'h00, 0, 0,  1, 0, 0, 1, 0, 0);
        add(8'h00, 0, 0,  1, 0, 0, 1, 0, 0);
        add(8'h00, 0, 0,  1, 0, 0, 1, 0, 0);
        add(8'h00, 0, 0,  1, 0, 0, 1, 0, 0);
        add(8'h00, 0, 1,  1, 7, 0, 1, 0, 0);
        add(8'h00, 0, 1,  1, 0, 1, 1, 0, 0);
        add(8'h00, 0, 0,  1, 0, 1, 1, 0, 0);
        add(8'h00, 0, 1,  0, 0, 0, 0, 0, 0);
        // drop: bit 3 pulsed twice
        add(8'h08, 0, 1,  0, 0, 0, 0, 0, 0);
        add(8'h08, 0, 1,  0, 0, 0, 0, 1, 0);
        add(8'h00, 1, 1,  1, 3, 0, 1, 1, 0);
        add(8'h00, 0, 1,  1, 0, 1, 1, 1, 0);
        add(8'h00, 0, 1,  0, 0, 0, 0, 1, 0);
        // overrun: tick during SEND with a new spike on bit 1
        add(8'h11, 0, 1,  0, 0, 0, 0, 1, 0);
        add(8'h00, 1, 1,  1, 0, 0, 1, 1, 0);
        add(8'h02, 1, 1,  1, 4, 0, 1, 1, 1);
        add(8'h00, 0, 1,  1, 0, 1, 1, 1, 1);
        add(8'h00, 0, 1,  0, 0, 0, 0, 1, 1);
        add(8'h00, 0, 1,  0, 0, 0, 0, 1, 1);
        // carried bit 1 plus a spike coincident with the tick (bit 6)
        add(8'h40, 1, 1,  1, 1, 0, 1, 1, 1);
        add(8'h00, 0, 1,  1, 6, 0, 1, 1, 1);
        add(8'h00, 0, 1,  1, 0, 1, 1, 1, 1);
        add(8'h00, 0, 1,  0, 0, 0, 0, 1, 1);

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("reset", 0, 0, 0, 0, 0, 0);
        chk("reset.drop2", 32'(drop_cnt2), 32'd0);
        #3 reset_n = 1'b1;
        step();

        // ---- table ----
        for (int i = 0; i < vq.size(); i++) begin
            spike_in = vq[i].spike;
            tick = vq[i].tick;
            aer1.aer_ready = vq[i].ready;
            step();
            chk_outputs($sformatf("v%0d", i), vq[i].exp_valid, vq[i].exp_addr,
                        vq[i].exp_eot, vq[i].exp_busy, vq[i].exp_drop, vq[i].exp_ovr);
        end
        spike_in = '0;
        tick = 1'b0;
        aer1.aer_ready = 1'b1;

        // ---- saturation on the 2-bit counter: bit 3 pulsed 7 times ----
        spike_in2 = 8'h08;
        step();
        chk("sat.first", 32'(drop_cnt2), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("sat.p%0d", k), 32'(drop_cnt2), 32'((k > 3) ? 3 : k));
        end
        spike_in2 = '0;
        step();
        chk("sat.hold", 32'(drop_cnt2), 32'd3);
        chk("sat.nobusy", 32'(busy2), 32'd0);

        // ---- reset mid-drain ----
        spike_in = 8'h0C;
        step();
        spike_in = 8'h00;
        tick = 1'b1;
        step();
        chk("mid.addr", 32'(aer1.aer_addr), 32'd2);
        chk("mid.valid", 32'(aer1.aer_valid), 32'd1);
        tick = 1'b0;
        aer1.aer_ready = 1'b0;
        spike_in = 8'h10;          // lands in pending, must be wiped by reset
        step();
        spike_in = 8'h00;
        chk("mid.hold", 32'(aer1.aer_addr), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        chk_outputs("async_rst", 0, 0, 0, 0, 0, 0);
        chk("async_rst.state", 32'(dbg_state), 32'(IDLE));
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        aer1.aer_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post_rst.valid%0d", k), 32'(aer1.aer_valid), 32'd0);
            chk($sformatf("post_rst.busy%0d", k), 32'(busy), 32'd0);
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk_outputs("post_rst.tick", 1, 0, 1, 1, 0, 0);
        step();
        chk_outputs("post_rst.idle", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
